// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl
// Mid-block pedestrian-crossing controller. A Moore state machine sequences the
// car lights (green/yellow/red) and the WALK / DONT_WALK lamps. A one-cycle
// debounced request pulse is latched as a pending request. Every accepted
// request bumps a wrapping counter that drives the 7-segment display.
// All phase durations are measured in ticks from an internal prescaler.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   ped_btn      debounced pedestrian request pulse, synchronous to clk
//   car_green    car green lamp
//   car_yellow   car yellow lamp
//   car_red      car red lamp
//   walk         pedestrian WALK lamp
//   dont_walk    pedestrian DONT_WALK lamp (steady, or flashing in FLASH)
//   ped_waiting  a request has been latched and not yet served
//   ped_count    number of accepted requests, wraps modulo 2^CNT_W
//   state        current state code (debug / LEDs)
module ped_xing_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 8,
  parameter int unsigned FLASH_T   = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_btn,
  output logic             car_green,
  output logic             car_yellow,
  output logic             car_red,
  output logic             walk,
  output logic             dont_walk,
  output logic             ped_waiting,
  output logic [CNT_W-1:0] ped_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_GREEN   = 3'd0,
    ST_YELLOW  = 3'd1,
    ST_ALLRED1 = 3'd2,
    ST_WALK    = 3'd3,
    ST_FLASH   = 3'd4,
    ST_ALLRED2 = 3'd5
  } state_t;

  localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0] GREEN_LIM  = 32'(GREEN_MIN);
  localparam logic [31:0] YELLOW_LIM = 32'(YELLOW_T);
  localparam logic [31:0] ALLRED_LIM = 32'(ALLRED_T);
  localparam logic [31:0] WALK_LIM   = 32'(WALK_T);
  localparam logic [31:0] FLASH_LIM  = 32'(FLASH_T);

  state_t      state_q;
  state_t      state_n;
  logic [31:0] prescaler;
  logic [31:0] elapsed;
  logic [31:0] elapsed_inc;
  logic        tick;
  logic        accept;
  logic        enter_walk;

  // A timed state ends on the edge where its last tick completes, so the
  // comparisons below look at the elapsed count *after* this tick is taken.
  // Doing so makes a state of N ticks last exactly N*TICK_DIV cycles.
  assign tick        = (prescaler == TICK_LAST);
  assign elapsed_inc = elapsed + 32'd1;

  // A press is accepted only when nothing is pending and pedestrians are not
  // already crossing. The edge that enters WALK serves the pending request,
  // and that takes priority over any press arriving on the same edge.
  assign accept     = ped_btn && !ped_waiting && (state_q != ST_WALK);
  assign enter_walk = (state_q == ST_ALLRED1) && (state_n == ST_WALK);

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_GREEN;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic. GREEN may leave either when GREEN_MIN is reached on
  // this tick with a request already pending, or on any later edge once a
  // request shows up (elapsed has saturated at GREEN_MIN by then).
  // The unused codes 6 and 7 fall back to GREEN.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_GREEN: begin
        if (ped_waiting &&
            ((elapsed == GREEN_LIM) || (tick && (elapsed_inc == GREEN_LIM)))) begin
          state_n = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (tick && (elapsed_inc == YELLOW_LIM)) begin
          state_n = ST_ALLRED1;
        end
      end
      ST_ALLRED1: begin
        if (tick && (elapsed_inc == ALLRED_LIM)) begin
          state_n = ST_WALK;
        end
      end
      ST_WALK: begin
        if (tick && (elapsed_inc == WALK_LIM)) begin
          state_n = ST_FLASH;
        end
      end
      ST_FLASH: begin
        if (tick && (elapsed_inc == FLASH_LIM)) begin
          state_n = ST_ALLRED2;
        end
      end
      ST_ALLRED2: begin
        if (tick && (elapsed_inc == ALLRED_LIM)) begin
          state_n = ST_GREEN;
        end
      end
      default: begin
        state_n = ST_GREEN;
      end
    endcase
  end

  // Prescaler and tick counter. Both restart on every state change so each
  // phase is timed from its own entry. In GREEN the tick count stops at
  // GREEN_MIN so an idle road can sit in GREEN indefinitely without overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= 32'd0;
      elapsed   <= 32'd0;
    end else if (state_n != state_q) begin
      prescaler <= 32'd0;
      elapsed   <= 32'd0;
    end else if (tick) begin
      prescaler <= 32'd0;
      if (!((state_q == ST_GREEN) && (elapsed >= GREEN_LIM))) begin
        elapsed <= elapsed_inc;
      end
    end else begin
      prescaler <= prescaler + 32'd1;
    end
  end

  // Request latch and accepted-request counter. The counter wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_waiting <= 1'b0;
      ped_count   <= '0;
    end else if (enter_walk) begin
      ped_waiting <= 1'b0;
    end else if (accept) begin
      ped_waiting <= 1'b1;
      ped_count   <= ped_count + CNT_W'(1);
    end
  end

  // Lamp decode from state alone. DONT_WALK flashes during FLASH by following
  // the parity of the tick count: lit on even ticks, dark on odd ones.
  // Unused codes show all-red with DONT_WALK as the safe fallback.
  always_comb begin
    car_green  = 1'b0;
    car_yellow = 1'b0;
    car_red    = 1'b0;
    walk       = 1'b0;
    dont_walk  = 1'b0;
    case (state_q)
      ST_GREEN: begin
        car_green = 1'b1;
        dont_walk = 1'b1;
      end
      ST_YELLOW: begin
        car_yellow = 1'b1;
        dont_walk  = 1'b1;
      end
      ST_ALLRED1, ST_ALLRED2: begin
        car_red   = 1'b1;
        dont_walk = 1'b1;
      end
      ST_WALK: begin
        car_red = 1'b1;
        walk    = 1'b1;
      end
      ST_FLASH: begin
        car_red   = 1'b1;
        dont_walk = ~elapsed[0];
      end
      default: begin
        car_red   = 1'b1;
        dont_walk = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// tb_ped_xing_ctrl
// Self-checking bench for ped_xing_ctrl using small timing parameters. A
// behavioural reference model tracks the phase, the number of cycles spent in
// it, the pending flag and the request count. Phase lengths come straight
// from tick counts times TICK_DIV, and the flashing lamp follows the
// cycle offset inside FLASH.
module tb_ped_xing_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int GREEN_MIN = 3;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 2;
  localparam int FLASH_T   = 2;
  localparam int CNT_W     = 4;

  localparam logic [12:0] RESET_VEC = {3'd0, 5'b10001, 1'b0, 4'd0};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ped_btn = 1'b0;
  logic             car_green;
  logic             car_yellow;
  logic             car_red;
  logic             walk;
  logic             dont_walk;
  logic             ped_waiting;
  logic [CNT_W-1:0] ped_count;
  logic [2:0]       state;
  logic [12:0]      obs;

  int total = 0;
  int bad   = 0;

  int               m_phase;
  int               m_t;
  logic             m_wait;
  logic [CNT_W-1:0] m_count;

  ped_xing_ctrl #(
    .TICK_DIV (TICK_DIV),
    .GREEN_MIN(GREEN_MIN),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .WALK_T   (WALK_T),
    .FLASH_T  (FLASH_T),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ped_btn    (ped_btn),
    .car_green  (car_green),
    .car_yellow (car_yellow),
    .car_red    (car_red),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .ped_waiting(ped_waiting),
    .ped_count  (ped_count),
    .state      (state)
  );

  assign obs = {state, car_green, car_yellow, car_red, walk, dont_walk, ped_waiting, ped_count};

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Phase lengths in ticks, for the timed phases.
  function automatic int phase_ticks(input int p);
    case (p)
      1:       return YELLOW_T;
      2:       return ALLRED_T;
      3:       return WALK_T;
      4:       return FLASH_T;
      default: return ALLRED_T;
    endcase
  endfunction

  // Expected output vector from the model.
  function automatic logic [12:0] expected();
    logic [4:0] lamps;
    logic       dw;
    dw = (((m_t / TICK_DIV) % 2) == 0);
    case (m_phase)
      0:       lamps = 5'b10001;
      1:       lamps = 5'b01001;
      2, 5:    lamps = 5'b00101;
      3:       lamps = 5'b00110;
      default: lamps = {4'b0010, dw};
    endcase
    return {3'(m_phase), lamps, m_wait, m_count};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_wait  = 1'b0;
    m_count = '0;
  endtask

  // Advance the model by one clock edge using the values before that edge.
  task automatic model_advance(input logic btn);
    logic leave;
    logic accept;
    logic enter_walk;
    if (m_phase == 0) leave = m_wait && ((m_t + 1) >= GREEN_MIN * TICK_DIV);
    else              leave = ((m_t + 1) == phase_ticks(m_phase) * TICK_DIV);
    enter_walk = leave && (m_phase == 2);
    accept     = btn && !m_wait && (m_phase != 3);
    if (enter_walk) begin
      m_wait = 1'b0;
    end else if (accept) begin
      m_wait  = 1'b1;
      m_count = m_count + CNT_W'(1);
    end
    if (leave) begin
      m_phase = (m_phase + 1) % 6;
      m_t     = 0;
    end else begin
      m_t = m_t + 1;
    end
  endtask

  // Drive one cycle of ped_btn, then leave the bench 1 time unit past the edge.
  task automatic step(input logic btn);
    ped_btn = btn;
    @(posedge clk);
    model_advance(btn);
    #1;
    ped_btn = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    ped_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Step with no presses until the model reaches phase p.
  task automatic run_until(input int p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == p) begin
        ok = 1'b1;
        break;
      end
      step(1'b0);
    end
  endtask

  task automatic test_reset();
    ped_btn = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL reset_hold1 got=%h want=%h", obs, RESET_VEC);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL reset_hold2 got=%h want=%h", obs, RESET_VEC);
    end
    ped_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if (obs !== expected()) begin
      bad++;
      $display("[TB] FAIL reset_release got=%h want=%h", obs, expected());
    end
  endtask

  task automatic test_idle();
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b0);
      total++;
      if (obs !== expected()) begin
        bad++;
        $display("[TB] FAIL idle cyc=%0d got=%h want=%h", i, obs, expected());
      end
    end
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL idle_end got=%h want=%h", obs, RESET_VEC);
    end
  endtask

  task automatic test_basic_request();
    int  hist[6] = '{default: 0};
    int  want[6] = '{12, 8, 4, 8, 8, 4};
    bit  left_green = 1'b0;
    bit  back = 1'b0;
    bit  walk_seen = 1'b0;
    apply_reset();
    total++;
    if (obs !== expected()) begin
      bad++;
      $display("[TB] FAIL basic_start got=%h want=%h", obs, expected());
    end
    hist[state]++;
    for (int i = 0; i < 100; i++) begin
      step(i == 2);
      total++;
      if (obs !== expected()) begin
        bad++;
        $display("[TB] FAIL basic cyc=%0d got=%h want=%h", i, obs, expected());
      end
      if (i == 2) begin
        total++;
        if ({ped_waiting, ped_count} !== 5'b1_0001) begin
          bad++;
          $display("[TB] FAIL basic_accept got=%b want=%b", {ped_waiting, ped_count}, 5'b1_0001);
        end
      end
      if (state != 3'd0) left_green = 1'b1;
      else if (left_green) begin
        back = 1'b1;
        break;
      end
      if (state < 3'd6) hist[state]++;
      if (state == 3'd3 && !walk_seen) begin
        walk_seen = 1'b1;
        total++;
        if (ped_waiting !== 1'b0) begin
          bad++;
          $display("[TB] FAIL basic_walk_clear got=%b want=0", ped_waiting);
        end
      end
    end
    total++;
    if (!back) begin
      bad++;
      $display("[TB] FAIL basic_timeout got=no_return want=GREEN");
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (hist[k] !== want[k]) begin
        bad++;
        $display("[TB] FAIL basic_len state=%0d got=%0d want=%0d", k, hist[k], want[k]);
      end
    end
  endtask

  task automatic test_ignored_presses();
    int   hist[6] = '{default: 0};
    int   want[6] = '{12, 8, 4, 8, 8, 4};
    bit   left_green = 1'b0;
    bit   back = 1'b0;
    bit   walk_pressed = 1'b0;
    logic btn;
    apply_reset();
    hist[state]++;
    for (int i = 0; i < 100; i++) begin
      btn = (i == 0) || (i == 2) || (i == 4) || (i == 6);
      if (m_phase == 3 && !walk_pressed) begin
        btn = 1'b1;
        walk_pressed = 1'b1;
      end
      step(btn);
      total++;
      if (obs !== expected()) begin
        bad++;
        $display("[TB] FAIL ignored cyc=%0d got=%h want=%h", i, obs, expected());
      end
      if (state != 3'd0) left_green = 1'b1;
      else if (left_green) begin
        back = 1'b1;
        break;
      end
      if (state < 3'd6) hist[state]++;
    end
    total++;
    if (!back || !walk_pressed) begin
      bad++;
      $display("[TB] FAIL ignored_timeout got=back%0d_walk%0d want=back1_walk1", back, walk_pressed);
    end
    total++;
    if (ped_count !== 4'd1) begin
      bad++;
      $display("[TB] FAIL ignored_count got=%0d want=1", ped_count);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (hist[k] !== want[k]) begin
        bad++;
        $display("[TB] FAIL ignored_len state=%0d got=%0d want=%0d", k, hist[k], want[k]);
      end
    end
  endtask

  task automatic test_flash_press();
    bit ok;
    int green;
    apply_reset();
    step(1'b1);
    run_until(4, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL flash_reach got=timeout want=FLASH");
    end
    step(1'b1);
    total++;
    if ({ped_waiting, ped_count} !== 5'b1_0010) begin
      bad++;
      $display("[TB] FAIL flash_accept got=%b want=%b", {ped_waiting, ped_count}, 5'b1_0010);
    end
    run_until(0, 200, ok);
    total++;
    if (!ok || state !== 3'd0) begin
      bad++;
      $display("[TB] FAIL flash_green_entry got=%0d want=0", state);
    end
    green = 1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      total++;
      if (obs !== expected()) begin
        bad++;
        $display("[TB] FAIL flash_green cyc=%0d got=%h want=%h", i, obs, expected());
      end
      if (state != 3'd0) break;
      green++;
    end
    total++;
    if (green !== 12) begin
      bad++;
      $display("[TB] FAIL flash_green_len got=%0d want=12", green);
    end
    run_until(0, 200, ok);
    for (int i = 0; i < 20; i++) step(1'b0);
    total++;
    if (!ok || obs !== expected()) begin
      bad++;
      $display("[TB] FAIL idle_green got=%h want=%h", obs, expected());
    end
    step(1'b1);
    total++;
    if ({state, ped_waiting} !== 4'b000_1) begin
      bad++;
      $display("[TB] FAIL idle_press1 got=%b want=%b", {state, ped_waiting}, 4'b000_1);
    end
    step(1'b0);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("[TB] FAIL idle_press2 got=%0d want=1", state);
    end
  endtask

  task automatic test_reset_mid_walk();
    bit ok;
    apply_reset();
    step(1'b1);
    run_until(3, 200, ok);
    step(1'b0);
    total++;
    if (!ok || walk !== 1'b1 || ped_count !== 4'd1) begin
      bad++;
      $display("[TB] FAIL midwalk_pre got=walk%b_cnt%0d want=walk1_cnt1", walk, ped_count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL midwalk_async got=%h want=%h", obs, RESET_VEC);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL midwalk_hold got=%h want=%h", obs, RESET_VEC);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_wrap();
    int   accepts = 0;
    logic btn;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      btn = !m_wait && (m_phase != 3);
      step(btn);
      if (btn) accepts++;
      total++;
      if (obs !== expected()) begin
        bad++;
        $display("[TB] FAIL wrap cyc=%0d got=%h want=%h", i, obs, expected());
      end
      if (btn && accepts == 15) begin
        total++;
        if (ped_count !== 4'd15) begin
          bad++;
          $display("[TB] FAIL wrap_15 got=%0d want=15", ped_count);
        end
      end
      if (accepts == 16) break;
    end
    total++;
    if (accepts != 16 || {ped_waiting, ped_count} !== 5'b1_0000) begin
      bad++;
      $display("[TB] FAIL wrap_zero got=%b want=%b", {ped_waiting, ped_count}, 5'b1_0000);
    end
  endtask

  task automatic test_random();
    logic btn;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      btn = ($urandom_range(0, 7) == 0);
      step(btn);
      total++;
      if (obs !== expected()) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%h want=%h", i, obs, expected());
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_basic_request();
    test_ignored_presses();
    test_flash_press();
    test_reset_mid_walk();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
